// File: rtl/fifo_flex_if.sv
// -----------------------------------------------------------------------------
// fifo_flex_if
// Bundle of the request/response signals of the fifo_flex buffer.
//
// Handshake: a write (wrreq_i) or read (rdreq_i) request is sampled at the
// rising clock edge and is taken only when the FIFO can honour it
// (not full_o / not empty_o, and no flush_i in the same cycle). There is no
// per-request ready: full_o/empty_o are the ready indications, and a request
// made against them is dropped and reported by overflow_o/underflow_o.
//
// Modports:
//   master : producer/consumer side (drives requests, observes status)
//   slave  : the FIFO itself
// -----------------------------------------------------------------------------
interface fifo_flex_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 4
);
   logic              flush_i;
   logic [DWIDTH-1:0] data_i;
   logic              wrreq_i;
   logic              rdreq_i;
   logic [DWIDTH-1:0] q_o;
   logic              empty_o;
   logic              full_o;
   logic [AWIDTH:0]   usedw_o;
   logic              almost_full_o;
   logic              almost_empty_o;
   logic              overflow_o;
   logic              underflow_o;

   modport master (
      output flush_i, data_i, wrreq_i, rdreq_i,
      input  q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o,
             overflow_o, underflow_o
   );

   modport slave (
      input  flush_i, data_i, wrreq_i, rdreq_i,
      output q_o, empty_o, full_o, usedw_o, almost_full_o, almost_empty_o,
             overflow_o, underflow_o
   );
endinterface

// File: rtl/fifo_flex.sv
// -----------------------------------------------------------------------------
// fifo_flex
// Single-clock synchronous FIFO, DEPTH = 2**AWIDTH words of DWIDTH bits.
// SHOWAHEAD=1 : head word is presented on q_o while the FIFO is not empty;
//               rdreq_i acknowledges (pops) it.
// SHOWAHEAD=0 : a read loads the head word into q_o; REGISTER_OUTPUT=1 adds
//               one more register stage on q_o.
// Status flags and error pulses are all registered.
//
// Ports:
//   clk_i  : clock, rising edge
//   arst_i : asynchronous active-high reset
//   bus    : fifo_flex_if.slave (flush, write/read requests, data, status)
// -----------------------------------------------------------------------------
module fifo_flex #(
   parameter int DWIDTH             = 32,
   parameter int AWIDTH             = 4,
   parameter bit SHOWAHEAD          = 1'b1,
   parameter bit REGISTER_OUTPUT    = 1'b0,
   parameter int ALMOST_FULL_VALUE  = 12,
   parameter int ALMOST_EMPTY_VALUE = 4
) (
   input logic        clk_i,
   input logic        arst_i,
   fifo_flex_if.slave bus
);
   localparam int DEPTH = 1 << AWIDTH;
   localparam int CW    = AWIDTH + 1;

   localparam logic [AWIDTH:0] DEPTH_W = CW'(DEPTH);
   localparam logic [AWIDTH:0] AF_W    = CW'(ALMOST_FULL_VALUE);
   localparam logic [AWIDTH:0] AE_W    = CW'(ALMOST_EMPTY_VALUE);
   localparam logic            AE_RST  = (ALMOST_EMPTY_VALUE > 0);

   // Parameter sanity checks
   if (AWIDTH < 1) begin : g_chk_aw
      $error("fifo_flex: AWIDTH must be >= 1");
   end
   if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > DEPTH) begin : g_chk_af
      $error("fifo_flex: ALMOST_FULL_VALUE must be in 1..DEPTH");
   end
   if (ALMOST_EMPTY_VALUE < 0 || ALMOST_EMPTY_VALUE > DEPTH) begin : g_chk_ae
      $error("fifo_flex: ALMOST_EMPTY_VALUE must be in 0..DEPTH");
   end

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [AWIDTH-1:0] rd_ptr;
   logic [AWIDTH-1:0] wr_ptr;
   logic [AWIDTH:0]   usedw;
   logic [AWIDTH:0]   usedw_nxt;
   logic              empty;
   logic              full;
   logic              almost_full;
   logic              almost_empty;
   logic              overflow;
   logic              underflow;
   logic              wr_acc;
   logic              rd_acc;

   // Accept decisions use only registered flags, so a read at full frees no
   // space for a write in the same cycle (and vice versa at empty).
   assign wr_acc = bus.wrreq_i && !full  && !bus.flush_i;
   assign rd_acc = bus.rdreq_i && !empty && !bus.flush_i;

   always_comb begin
      usedw_nxt = usedw;
      if (bus.flush_i) begin
         usedw_nxt = '0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   usedw_nxt = usedw + 1'b1;
            2'b01:   usedw_nxt = usedw - 1'b1;
            default: usedw_nxt = usedw;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         usedw        <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= AE_RST;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (bus.flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         end
         // Flags follow the next count so they change on the same edge.
         usedw        <= usedw_nxt;
         empty        <= (usedw_nxt == '0);
         full         <= (usedw_nxt == DEPTH_W);
         almost_full  <= (usedw_nxt >= AF_W);
         almost_empty <= (usedw_nxt < AE_W);
         overflow     <= bus.wrreq_i && full  && !bus.flush_i;
         underflow    <= bus.rdreq_i && empty && !bus.flush_i;
      end
   end

   // Storage is not reset.
   always_ff @(posedge clk_i) begin
      if (wr_acc) mem[wr_ptr] <= bus.data_i;
   end

   if (SHOWAHEAD) begin : g_showahead
      // Head word straight from memory; forced to 0 while empty so reset
      // shows a defined value.
      assign bus.q_o = empty ? '0 : mem[rd_ptr];
   end else begin : g_normal
      logic [DWIDTH-1:0] rdata;

      always_ff @(posedge clk_i or posedge arst_i) begin
         if (arst_i)      rdata <= '0;
         else if (rd_acc) rdata <= mem[rd_ptr];
      end

      if (REGISTER_OUTPUT) begin : g_oreg
         logic [DWIDTH-1:0] q_reg;
         always_ff @(posedge clk_i or posedge arst_i) begin
            if (arst_i) q_reg <= '0;
            else        q_reg <= rdata;
         end
         assign bus.q_o = q_reg;
      end else begin : g_noreg
         assign bus.q_o = rdata;
      end
   end

   assign bus.usedw_o        = usedw;
   assign bus.empty_o        = empty;
   assign bus.full_o         = full;
   assign bus.almost_full_o  = almost_full;
   assign bus.almost_empty_o = almost_empty;
   assign bus.overflow_o     = overflow;
   assign bus.underflow_o    = underflow;
endmodule

// File: tb/tb_fifo_flex.sv
// -----------------------------------------------------------------------------
// tb_fifo_flex
// Drives two fifo_flex instances with identical requests:
//   u_sa : SHOWAHEAD=1
//   u_nm : SHOWAHEAD=0, REGISTER_OUTPUT=1
// A small reference model (expected queue, count, q pipeline for normal mode)
// is checked after every clock edge, plus hand-computed directed checks.
// -----------------------------------------------------------------------------
module tb_fifo_flex;
   localparam int DW = 32;
   localparam int AW = 4;
   localparam int DEPTH = 16;

   logic clk_i;
   logic arst_i;

   fifo_flex_if #(.DWIDTH(DW), .AWIDTH(AW)) bus_a ();
   fifo_flex_if #(.DWIDTH(DW), .AWIDTH(AW)) bus_b ();

   fifo_flex #(
      .DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD(1'b1), .REGISTER_OUTPUT(1'b0),
      .ALMOST_FULL_VALUE(12), .ALMOST_EMPTY_VALUE(4)
   ) u_sa (.clk_i(clk_i), .arst_i(arst_i), .bus(bus_a));

   fifo_flex #(
      .DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD(1'b0), .REGISTER_OUTPUT(1'b1),
      .ALMOST_FULL_VALUE(12), .ALMOST_EMPTY_VALUE(4)
   ) u_nm (.clk_i(clk_i), .arst_i(arst_i), .bus(bus_b));

   // ---------------- clock / reset ----------------
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard / model ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [DW-1:0] exp_q[$];
   int            cnt;
   logic [DW-1:0] nm_pend;
   logic [DW-1:0] nm_q;
   logic          e_ovf;
   logic          e_unf;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic check_all();
      check("usedw_a", 32'(bus_a.usedw_o), 32'(cnt));
      check("usedw_b", 32'(bus_b.usedw_o), 32'(cnt));
      check("empty_a", 32'(bus_a.empty_o), 32'(cnt == 0));
      check("empty_b", 32'(bus_b.empty_o), 32'(cnt == 0));
      check("full_a",  32'(bus_a.full_o),  32'(cnt == DEPTH));
      check("full_b",  32'(bus_b.full_o),  32'(cnt == DEPTH));
      check("afull_a", 32'(bus_a.almost_full_o),  32'(cnt >= 12));
      check("afull_b", 32'(bus_b.almost_full_o),  32'(cnt >= 12));
      check("aempt_a", 32'(bus_a.almost_empty_o), 32'(cnt < 4));
      check("aempt_b", 32'(bus_b.almost_empty_o), 32'(cnt < 4));
      check("ovf_a",   32'(bus_a.overflow_o),  32'(e_ovf));
      check("ovf_b",   32'(bus_b.overflow_o),  32'(e_ovf));
      check("unf_a",   32'(bus_a.underflow_o), 32'(e_unf));
      check("unf_b",   32'(bus_b.underflow_o), 32'(e_unf));
      if (cnt > 0) check("q_head_a", bus_a.q_o, exp_q[0]);
      check("q_b", bus_b.q_o, nm_q);
   endtask

   task automatic model_reset();
      exp_q.delete();
      cnt     = 0;
      nm_pend = '0;
      nm_q    = '0;
      e_ovf   = 1'b0;
      e_unf   = 1'b0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic wr, input logic rd, input logic fl, input logic [DW-1:0] d);
      bus_a.wrreq_i = wr; bus_a.rdreq_i = rd; bus_a.flush_i = fl; bus_a.data_i = d;
      bus_b.wrreq_i = wr; bus_b.rdreq_i = rd; bus_b.flush_i = fl; bus_b.data_i = d;
   endtask

   // One clock with the given requests, then model update and full check.
   task automatic cycle(input logic wr, input logic rd, input logic fl, input logic [DW-1:0] d);
      logic wa, ra;
      drive(wr, rd, fl, d);
      wa    = wr && (cnt < DEPTH) && !fl;
      ra    = rd && (cnt != 0) && !fl;
      e_ovf = wr && (cnt == DEPTH) && !fl;
      e_unf = rd && (cnt == 0) && !fl;
      @(posedge clk_i);
      #1;
      nm_q = nm_pend;
      if (ra) nm_pend = exp_q[0];
      if (fl) begin
         exp_q.delete();
      end else begin
         if (ra) void'(exp_q.pop_front());
         if (wa) exp_q.push_back(d);
      end
      cnt = exp_q.size();
      drive(1'b0, 1'b0, 1'b0, '0);
      check_all();
   endtask

   task automatic wr_word(input logic [DW-1:0] d);
      cycle(1'b1, 1'b0, 1'b0, d);
   endtask

   task automatic rd_word();
      cycle(1'b0, 1'b1, 1'b0, '0);
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, '0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int nw;
      int guard;
      logic wr, rd;

      arst_i = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0);
      model_reset();
      repeat (2) @(posedge clk_i);
      #1;
      check_all();
      check("rst_q_a", bus_a.q_o, 32'h0);
      #2 arst_i = 1'b0;

      // 1: async reset between edges after 5 writes
      for (int i = 0; i < 5; i++) wr_word(32'h100 + 32'(i));
      check("t1_usedw5", 32'(bus_a.usedw_o), 32'd5);
      #2 arst_i = 1'b1;
      #1;
      check("t1_arst_usedw", 32'(bus_a.usedw_o), 32'd0);
      check("t1_arst_empty", 32'(bus_a.empty_o), 32'd1);
      check("t1_arst_q_a",   bus_a.q_o, 32'h0);
      check("t1_arst_q_b",   bus_b.q_o, 32'h0);
      check("t1_arst_ae",    32'(bus_b.almost_empty_o), 32'd1);
      #1 arst_i = 1'b0;
      model_reset();

      // 2: fill to full, almost_full from the 12th write, overflow on 17th
      for (int i = 0; i < 16; i++) begin
         wr_word(32'(i + 1));
         if (i == 10) check("t2_af_at11", 32'(bus_a.almost_full_o), 32'd0);
         if (i == 11) check("t2_af_at12", 32'(bus_a.almost_full_o), 32'd1);
      end
      check("t2_full",  32'(bus_a.full_o),  32'd1);
      check("t2_usedw", 32'(bus_a.usedw_o), 32'd16);
      wr_word(32'hDEAD);
      check("t2_ovf_pulse", 32'(bus_a.overflow_o), 32'd1);
      check("t2_usedw_hold", 32'(bus_b.usedw_o), 32'd16);
      idle();
      check("t2_ovf_end", 32'(bus_a.overflow_o), 32'd0);
      check("t2_head", bus_a.q_o, 32'd1);
      for (int i = 0; i < 16; i++) rd_word();
      idle();
      check("t2_last_q_b", bus_b.q_o, 32'd16);

      // 3: showahead first-word-fall-through and underflow
      wr_word(32'hA5);
      check("t3_empty0", 32'(bus_a.empty_o), 32'd0);
      check("t3_q_a5",   bus_a.q_o, 32'hA5);
      rd_word();
      check("t3_empty1", 32'(bus_a.empty_o), 32'd1);
      check("t3_usedw0", 32'(bus_a.usedw_o), 32'd0);
      rd_word();
      check("t3_unf_pulse", 32'(bus_a.underflow_o), 32'd1);
      idle();
      check("t3_unf_end", 32'(bus_a.underflow_o), 32'd0);

      // 4: normal mode with output register: q one edge after the read edge
      wr_word(32'd1); wr_word(32'd2); wr_word(32'd3);
      rd_word();
      check("t4_q_edgeN",  bus_b.q_o, 32'hA5);
      rd_word();
      check("t4_q_1", bus_b.q_o, 32'd1);
      rd_word();
      check("t4_q_2", bus_b.q_o, 32'd2);
      idle();
      check("t4_q_3", bus_b.q_o, 32'd3);
      idle();
      check("t4_q_hold", bus_b.q_o, 32'd3);

      // 5: simultaneous read+write at 5, at full, at empty
      for (int i = 0; i < 5; i++) wr_word(32'h50 + 32'(i));
      cycle(1'b1, 1'b1, 1'b0, 32'h99);
      check("t5_mid_usedw", 32'(bus_a.usedw_o), 32'd5);
      for (int i = 0; i < 11; i++) wr_word(32'h60 + 32'(i));
      cycle(1'b1, 1'b1, 1'b0, 32'h77);
      check("t5_full_usedw", 32'(bus_a.usedw_o), 32'd15);
      check("t5_full_ovf",   32'(bus_a.overflow_o), 32'd1);
      for (int i = 0; i < 15; i++) rd_word();
      cycle(1'b1, 1'b1, 1'b0, 32'h88);
      check("t5_empty_usedw", 32'(bus_a.usedw_o), 32'd1);
      check("t5_empty_unf",   32'(bus_a.underflow_o), 32'd1);
      check("t5_empty_q",     bus_a.q_o, 32'h88);
      rd_word();

      // 6: interleaved traffic with random stalls across pointer wrap
      nw = 0;
      guard = 0;
      while ((nw < 40 || cnt > 0) && guard < 600) begin
         wr = (nw < 40) && ($urandom_range(0, 99) < 60);
         rd = ($urandom_range(0, 99) < 50);
         if (wr && cnt < DEPTH) begin
            cycle(wr, rd, 1'b0, 32'hC000_0000 + 32'(nw));
            nw++;
         end else begin
            cycle(1'b0, rd, 1'b0, '0);
         end
         guard++;
      end
      check("t6_drained", 32'(cnt == 0 && nw == 40), 32'd1);

      // flush at usedw 7
      for (int i = 0; i < 7; i++) wr_word(32'h700 + 32'(i));
      check("t6_usedw7", 32'(bus_a.usedw_o), 32'd7);
      cycle(1'b1, 1'b1, 1'b1, 32'hBAD);
      check("t6_flush_usedw", 32'(bus_a.usedw_o), 32'd0);
      check("t6_flush_empty", 32'(bus_b.empty_o), 32'd1);
      wr_word(32'h5A5A);
      check("t6_post_q_a", bus_a.q_o, 32'h5A5A);
      rd_word();
      idle();
      check("t6_post_q_b", bus_b.q_o, 32'h5A5A);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
